uid_auth_checker: RTL and testbench
===================================

UID_AUTH_CHECKER -- requirements
Module: uid_auth_checker

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: number of whitelist slots; power of two, 2..16.
REQ-002 Parameter MAX_FAILS, default 3: consecutive denials that trigger lockout; 1..15.
REQ-003 Parameter LOCKOUT_CYCLES, default 1000000: lockout duration in clk cycles; 1..2^24-1.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- card_detected  in  1  card present, from the card detector.
- start_auth  in  1  one-cycle request pulse from the card detector.
- card_uid  in  32  card UID; valid in the start_auth cycle.
- prog_we  in  1  whitelist write strobe.
- prog_addr  in  4  whitelist slot index.
- prog_uid  in  32  UID to store.
- prog_valid  in  1  slot enable bit to store.
- busy  out  1  high in SCAN and RESULT.
- auth_done  out  1  one-cycle result pulse.
- auth_granted  out  1  result of the last completed request; held.
- match_index  out  4  slot that matched; 0 when denied.
- auth_uid  out  32  UID of the last completed request.
- locked_out  out  1  high in LOCKOUT.
- fail_count  out  4  current consecutive-denial count.

Function
REQ-006 FSM states: IDLE, SCAN, RESULT, LOCKOUT.
REQ-007 IDLE, start_auth=1 and card_detected=1: latch card_uid into the internal UID register; slot index := 0; next state SCAN.
REQ-008 IDLE, start_auth=1 and card_detected=0: request ignored.
REQ-009 SCAN: exactly one slot compared per cycle, in ascending order.
REQ-010 SCAN, slot valid and stored UID == latched UID: record index and grant; next state RESULT. The first (lowest) match wins.
REQ-011 SCAN, last slot compared with no match: record deny; next state RESULT.
REQ-012 Latency, start_auth sampled in cycle T:
- match at slot k: auth_done in cycle T+k+2.
- no match: auth_done in cycle T+NUM_ENTRIES+1.
REQ-013 RESULT lasts one cycle. In that cycle:
- auth_done = 1.
- auth_granted, match_index and auth_uid update to the new result and hold until the next RESULT.
REQ-014 RESULT, grant: fail_count := 0; next state IDLE.
REQ-015 RESULT, deny: fail_count := fail_count + 1 (saturating at 15). If the new value equals MAX_FAILS, load the lockout timer with LOCKOUT_CYCLES and go to LOCKOUT; otherwise go to IDLE.
REQ-016 LOCKOUT:
- timer decrements each cycle.
- on the cycle the timer reaches 0: fail_count := 0; next state IDLE.
- locked_out = 1 for exactly LOCKOUT_CYCLES cycles.
REQ-017 start_auth during LOCKOUT, with card_detected=1, produces auth_done one cycle later with auth_granted=0, match_index=0, auth_uid=card_uid. fail_count and the timer are unchanged; the state stays LOCKOUT.
REQ-018 start_auth while busy=1 is ignored; it is not queued.
REQ-019 card_detected=0 in any SCAN cycle aborts the request:
- next state IDLE; no auth_done.
- fail_count, auth_granted, match_index and auth_uid unchanged.
REQ-020 prog_we=1 with busy=0 and prog_addr < NUM_ENTRIES writes prog_uid and prog_valid into the slot on that edge.
REQ-021 Writes with busy=1, or with prog_addr >= NUM_ENTRIES, are dropped.
REQ-022 A write in the same cycle as an accepted start_auth takes effect before the scan reads that slot.
REQ-023 All outputs are registered, except busy and locked_out, which decode directly from the state register.

Reset
REQ-024 rst=1 on a rising edge sets:
- state IDLE.
- all slot valid bits 0 and all slot UIDs 0.
- fail_count, lockout timer, auth_done, auth_granted, match_index and auth_uid all 0.
REQ-025 Reset in any state, including mid-SCAN or mid-LOCKOUT, takes effect on that edge; no auth_done follows.

Verification
REQ-026 Slot 5 = 0xDEADBEEF, valid; start_auth with card_uid 0xDEADBEEF at cycle T -> auth_done at T+7, auth_granted=1, match_index=5, fail_count=0.
REQ-027 Empty table; three requests with card_uid 0x12345678 (MAX_FAILS=3, LOCKOUT_CYCLES=20) -> each auth_done at T+9 with auth_granted=0; fail_count 1, 2, 3; locked_out high for exactly 20 cycles, then fail_count=0.
REQ-028 start_auth during LOCKOUT -> auth_done next cycle with auth_granted=0; fail_count stays 3; the lockout end cycle is unchanged.
REQ-029 card_detected dropped 2 cycles into SCAN -> no auth_done; state IDLE; fail_count unchanged.
REQ-030 Slots 2 and 6 both hold 0xCAFEF00D, valid -> match_index=2. Slot 2 valid=0 -> match_index=6. prog_we during busy -> table unchanged, checked by a rescan.
REQ-031 rst asserted mid-SCAN and mid-LOCKOUT -> all outputs 0 the next cycle; a previously matching UID is now denied (table cleared).

Source files
------------

// File: rtl/uid_auth_checker.sv
// uid_auth_checker: whitelist-based card UID authentication.
// A request latches the card UID, scans the whitelist one slot per cycle
// (lowest matching slot wins), reports the result for one cycle, and
// locks the reader out after MAX_FAILS consecutive denials.
module uid_auth_checker #(
  parameter int NUM_ENTRIES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_detected,
  input  logic        start_auth,
  input  logic [31:0] card_uid,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [31:0] prog_uid,
  input  logic        prog_valid,
  output logic        busy,
  output logic        auth_done,
  output logic        auth_granted,
  output logic [3:0]  match_index,
  output logic [31:0] auth_uid,
  output logic        locked_out,
  output logic [3:0]  fail_count
);

  localparam int          AW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [3:0]  LAST_IDX    = 4'(NUM_ENTRIES - 1);
  localparam logic [3:0]  MAX_FAILS_C = 4'(MAX_FAILS);
  localparam logic [23:0] LOCKOUT_C   = 24'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_RESULT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            uid_q, uid_d;
  logic [3:0]             idx_q, idx_d;
  logic [31:0]            tab_uid_q [NUM_ENTRIES];
  logic [31:0]            tab_uid_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tab_vld_q, tab_vld_d;
  logic [3:0]             fail_count_q, fail_count_d;
  logic [23:0]            timer_q, timer_d;
  logic                   auth_done_q, auth_done_d;
  logic                   auth_granted_q, auth_granted_d;
  logic [3:0]             match_index_q, match_index_d;
  logic [31:0]            auth_uid_q, auth_uid_d;

  logic                   busy_s;
  logic                   wr_en_s;
  logic [AW-1:0]          wr_idx_s;
  logic [AW-1:0]          scan_idx_s;
  logic                   hit_s;
  logic [3:0]             fc_inc_s;

  // Busy/lockout flags decode straight from the state register.
  always_comb begin
    busy_s     = (state_q == S_SCAN) || (state_q == S_RESULT);
    locked_out = (state_q == S_LOCKOUT);
  end

  // Whitelist write port: accepted only while idle/locked and in range.
  always_comb begin
    wr_idx_s = prog_addr[AW-1:0];
    wr_en_s  = prog_we && !busy_s && ({1'b0, prog_addr} < 5'(NUM_ENTRIES));
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tab_uid_d[i] = (wr_en_s && (wr_idx_s == AW'(i))) ? prog_uid : tab_uid_q[i];
      tab_vld_d[i] = (wr_en_s && (wr_idx_s == AW'(i))) ? prog_valid : tab_vld_q[i];
    end
  end

  // Compare of the slot currently addressed by the scan pointer.
  always_comb begin
    scan_idx_s = idx_q[AW-1:0];
    hit_s      = tab_vld_q[scan_idx_s] && (tab_uid_q[scan_idx_s] == uid_q);
    fc_inc_s   = (fail_count_q == 4'd15) ? 4'd15 : (fail_count_q + 4'd1);
  end

  // Next-state and result logic; result registers load on entry to RESULT.
  always_comb begin
    state_d        = state_q;
    uid_d          = uid_q;
    idx_d          = idx_q;
    fail_count_d   = fail_count_q;
    timer_d        = timer_q;
    auth_done_d    = 1'b0;
    auth_granted_d = auth_granted_q;
    match_index_d  = match_index_q;
    auth_uid_d     = auth_uid_q;
    case (state_q)
      S_IDLE: begin
        if (start_auth && card_detected) begin
          uid_d   = card_uid;
          idx_d   = 4'd0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (!card_detected) begin
          // Card pulled mid-scan: abandon silently.
          state_d = S_IDLE;
        end else if (hit_s) begin
          auth_done_d    = 1'b1;
          auth_granted_d = 1'b1;
          match_index_d  = idx_q;
          auth_uid_d     = uid_q;
          state_d        = S_RESULT;
        end else if (idx_q == LAST_IDX) begin
          auth_done_d    = 1'b1;
          auth_granted_d = 1'b0;
          match_index_d  = 4'd0;
          auth_uid_d     = uid_q;
          state_d        = S_RESULT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RESULT: begin
        if (auth_granted_q) begin
          fail_count_d = 4'd0;
          state_d      = S_IDLE;
        end else begin
          fail_count_d = fc_inc_s;
          if (fc_inc_s == MAX_FAILS_C) begin
            timer_d = LOCKOUT_C;
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        timer_d = timer_q - 24'd1;
        if (timer_q <= 24'd1) begin
          timer_d      = 24'd0;
          fail_count_d = 4'd0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_LOCKOUT;
        end
        // Requests while locked out are answered at once with a denial.
        if (start_auth && card_detected) begin
          auth_done_d    = 1'b1;
          auth_granted_d = 1'b0;
          match_index_d  = 4'd0;
          auth_uid_d     = card_uid;
        end else begin
          auth_done_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, whitelist and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      uid_q          <= 32'd0;
      idx_q          <= 4'd0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tab_uid_q[i] <= 32'd0;
      end
      tab_vld_q      <= '0;
      fail_count_q   <= 4'd0;
      timer_q        <= 24'd0;
      auth_done_q    <= 1'b0;
      auth_granted_q <= 1'b0;
      match_index_q  <= 4'd0;
      auth_uid_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      uid_q          <= uid_d;
      idx_q          <= idx_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tab_uid_q[i] <= tab_uid_d[i];
      end
      tab_vld_q      <= tab_vld_d;
      fail_count_q   <= fail_count_d;
      timer_q        <= timer_d;
      auth_done_q    <= auth_done_d;
      auth_granted_q <= auth_granted_d;
      match_index_q  <= match_index_d;
      auth_uid_q     <= auth_uid_d;
    end
  end

  assign busy         = busy_s;
  assign auth_done    = auth_done_q;
  assign auth_granted = auth_granted_q;
  assign match_index  = match_index_q;
  assign auth_uid     = auth_uid_q;
  assign fail_count   = fail_count_q;

endmodule

// File: tb/tb_uid_auth_checker.sv
// Directed self-checking bench for uid_auth_checker
// (NUM_ENTRIES=8, MAX_FAILS=3, LOCKOUT_CYCLES=20).
module tb_uid_auth_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_detected;
  logic        start_auth;
  logic [31:0] card_uid;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_uid;
  logic        prog_valid;
  logic        busy;
  logic        auth_done;
  logic        auth_granted;
  logic [3:0]  match_index;
  logic [31:0] auth_uid;
  logic        locked_out;
  logic [3:0]  fail_count;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int lock_cnt;
  logic seen;

  uid_auth_checker #(
    .NUM_ENTRIES(8),
    .MAX_FAILS(3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .card_detected(card_detected), .start_auth(start_auth),
    .card_uid(card_uid), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_uid(prog_uid), .prog_valid(prog_valid), .busy(busy),
    .auth_done(auth_done), .auth_granted(auth_granted), .match_index(match_index),
    .auth_uid(auth_uid), .locked_out(locked_out), .fail_count(fail_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [3:0] a, input logic [31:0] u, input logic v);
    prog_we = 1'b1; prog_addr = a; prog_uid = u; prog_valid = v;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Issue a request at the current negedge; lat = cycles until auth_done (0 = none).
  task automatic request(input logic [31:0] u, output int l);
    card_uid = u; start_auth = 1'b1; card_detected = 1'b1;
    l = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_auth = 1'b0;
      prog_we    = 1'b0;
      if (auth_done === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},         32'(busy),         32'd0);
    chk({tag, " auth_done"},    32'(auth_done),    32'd0);
    chk({tag, " auth_granted"}, 32'(auth_granted), 32'd0);
    chk({tag, " match_index"},  32'(match_index),  32'd0);
    chk({tag, " auth_uid"},     auth_uid,          32'd0);
    chk({tag, " locked_out"},   32'(locked_out),   32'd0);
    chk({tag, " fail_count"},   32'(fail_count),   32'd0);
  endtask

  initial begin
    rst = 1'b1; card_detected = 1'b1; start_auth = 1'b0; card_uid = 32'd0;
    prog_we = 1'b0; prog_addr = 4'd0; prog_uid = 32'd0; prog_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");

    // Single grant at slot 5: auth_done 7 cycles after start.
    prog(4'd5, 32'hDEADBEEF, 1'b1);
    request(32'hDEADBEEF, lat);
    chk("grant5 latency", 32'(lat), 32'd7);
    chk("grant5 granted", 32'(auth_granted), 32'd1);
    chk("grant5 index", 32'(match_index), 32'd5);
    chk("grant5 uid", auth_uid, 32'hDEADBEEF);
    chk("grant5 busy in result", 32'(busy), 32'd1);
    @(negedge clk);
    chk("grant5 done pulse", 32'(auth_done), 32'd0);
    chk("grant5 fail_count", 32'(fail_count), 32'd0);
    chk("grant5 idle", 32'(busy), 32'd0);

    // Card removed two cycles into the scan: aborted, nothing changes.
    card_uid = 32'h12345678; start_auth = 1'b1;
    @(negedge clk);
    start_auth = 1'b0;
    @(negedge clk);
    card_detected = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (auth_done === 1'b1) seen = 1'b1;
    end
    card_detected = 1'b1;
    chk("abort no done", 32'(seen), 32'd0);
    chk("abort idle", 32'(busy), 32'd0);
    chk("abort fail_count", 32'(fail_count), 32'd0);
    chk("abort granted held", 32'(auth_granted), 32'd1);
    chk("abort index held", 32'(match_index), 32'd5);
    chk("abort uid held", auth_uid, 32'hDEADBEEF);

    // Write in the same cycle as the start is seen by the scan.
    prog_we = 1'b1; prog_addr = 4'd0; prog_uid = 32'h0BADC0DE; prog_valid = 1'b1;
    request(32'h0BADC0DE, lat);
    chk("same-cycle write latency", 32'(lat), 32'd2);
    chk("same-cycle write index", 32'(match_index), 32'd0);
    chk("same-cycle write granted", 32'(auth_granted), 32'd1);
    @(negedge clk);

    // Lowest matching slot wins; invalid slot skipped.
    prog(4'd2, 32'hCAFEF00D, 1'b1);
    prog(4'd6, 32'hCAFEF00D, 1'b1);
    request(32'hCAFEF00D, lat);
    chk("dup latency", 32'(lat), 32'd4);
    chk("dup index", 32'(match_index), 32'd2);
    @(negedge clk);
    prog(4'd2, 32'hCAFEF00D, 1'b0);
    request(32'hCAFEF00D, lat);
    chk("skip invalid latency", 32'(lat), 32'd8);
    chk("skip invalid index", 32'(match_index), 32'd6);
    @(negedge clk);

    // Writes while busy are dropped.
    card_uid = 32'hCAFEF00D; start_auth = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start_auth = 1'b0;
      if (i == 1) begin
        prog_we = 1'b1; prog_addr = 4'd6; prog_uid = 32'd0; prog_valid = 1'b0;
      end
      if (auth_done === 1'b1) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    prog_we = 1'b0;
    chk("busy write scan latency", 32'(lat), 32'd8);
    chk("busy write scan index", 32'(match_index), 32'd6);
    // Out-of-range addresses alias slots 2 and 6 in their low bits; must be dropped.
    prog(4'd10, 32'hCAFEF00D, 1'b1);
    prog(4'd14, 32'h00000000, 1'b0);
    request(32'hCAFEF00D, lat);
    chk("rescan latency", 32'(lat), 32'd8);
    chk("rescan index", 32'(match_index), 32'd6);
    chk("rescan granted", 32'(auth_granted), 32'd1);
    @(negedge clk);

    // Three denials trigger a 20-cycle lockout.
    for (int j = 1; j <= 3; j++) begin
      request(32'h12345678, lat);
      chk("deny latency", 32'(lat), 32'd9);
      chk("deny granted", 32'(auth_granted), 32'd0);
      chk("deny index", 32'(match_index), 32'd0);
      chk("deny uid", auth_uid, 32'h12345678);
      @(negedge clk);
      chk("deny fail_count", 32'(fail_count), 32'(j));
    end
    lock_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (locked_out !== 1'b1) break;
      lock_cnt++;
      if (i == 5) begin
        start_auth = 1'b0;
        chk("lockout req done", 32'(auth_done), 32'd1);
        chk("lockout req granted", 32'(auth_granted), 32'd0);
        chk("lockout req index", 32'(match_index), 32'd0);
        chk("lockout req uid", auth_uid, 32'hAAAA5555);
        chk("lockout req fail_count", 32'(fail_count), 32'd3);
      end
      if (i == 6) chk("lockout req pulse", 32'(auth_done), 32'd0);
      if (i == 4) begin
        card_uid = 32'hAAAA5555; start_auth = 1'b1;
      end
      @(negedge clk);
    end
    chk("lockout length", 32'(lock_cnt), 32'd20);
    chk("lockout end fail_count", 32'(fail_count), 32'd0);
    chk("lockout end state", 32'(locked_out), 32'd0);

    // Reset mid-scan clears outputs and the table.
    card_uid = 32'hDEADBEEF; start_auth = 1'b1;
    @(negedge clk);
    start_auth = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst mid-scan");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (auth_done === 1'b1) seen = 1'b1;
    end
    chk("rst mid-scan no done", 32'(seen), 32'd0);
    request(32'hDEADBEEF, lat);
    chk("cleared table latency", 32'(lat), 32'd9);
    chk("cleared table granted", 32'(auth_granted), 32'd0);
    @(negedge clk);
    chk("cleared table fail_count", 32'(fail_count), 32'd1);

    // Reset mid-lockout.
    request(32'h12345678, lat);
    @(negedge clk);
    request(32'h12345678, lat);
    @(negedge clk);
    chk("pre-rst locked", 32'(locked_out), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("rst mid-lockout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
